// File: rtl/change_dispenser.sv
// Greedy change payout FSM offering one coin at a time over valid/ready.
// Define CHANGE_LIMIT_EN to reject start requests above 200 with an err pulse.
module change_dispenser #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] change_money,
  input  logic       abort,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [4:0] coin_type,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    OFFER,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] gap_cnt;
  logic       hs;
  logic [7:0] paid;
  logic       over_limit;

  function automatic logic [4:0] pick(input logic [7:0] amt);
    if (amt >= 8'd50) return 5'b10000;
    if (amt >= 8'd20) return 5'b01000;
    if (amt >= 8'd10) return 5'b00100;
    if (amt >= 8'd5)  return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic [7:0] value_of(input logic [4:0] t);
    logic [7:0] v;
    v = 8'd0;
    unique case (1'b1)
      t[4]:    v = 8'd50;
      t[3]:    v = 8'd20;
      t[2]:    v = 8'd10;
      t[1]:    v = 8'd5;
      t[0]:    v = 8'd1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

`ifdef CHANGE_LIMIT_EN
  assign over_limit = change_money > 8'd200;
`else
  assign over_limit = 1'b0;
`endif

  assign hs   = coin_valid & coin_ready;
  assign paid = remaining - value_of(coin_type);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      gap_cnt    <= 8'd0;
      coin_valid <= 1'b0;
      coin_type  <= 5'd0;
      remaining  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort && state != IDLE) begin
        // a coin taken on the abort edge is still owed off the balance
        state      <= IDLE;
        busy       <= 1'b0;
        coin_valid <= 1'b0;
        gap_cnt    <= 8'd0;
        if (hs) remaining <= paid;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && over_limit) begin
              err <= 1'b1;
            end else if (start) begin
              remaining <= change_money;
              busy      <= 1'b1;
              if (change_money == 8'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= SELECT;
              end
            end
          end
          SELECT: begin
            coin_type <= pick(remaining);
            state     <= OFFER;
          end
          OFFER: begin
            if (!coin_valid) begin
              coin_valid <= 1'b1;
            end else if (coin_ready) begin
              remaining  <= paid;
              coin_valid <= 1'b0;
              gap_cnt    <= 8'd0;
              if (paid == 8'd0) begin
                state <= DONE;
                done  <= 1'b1;
              end else if (GAP_CYCLES == 0) begin
                state <= SELECT;
              end else begin
                state <= GAP;
              end
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= 8'd0;
              state   <= SELECT;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised bench for change_dispenser against an event-level payout model.
// Directed scenarios pin the model with hand-computed coin lists.
module tb_change_dispenser;

  localparam int GAP = 2;
`ifdef CHANGE_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic [7:0] change_money;
  logic       abort;
  logic       coin_ready;
  logic       coin_valid;
  logic [4:0] coin_type;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       err;

  change_dispenser #(.GAP_CYCLES(GAP)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .change_money (change_money),
    .abort        (abort),
    .coin_ready   (coin_ready),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .remaining    (remaining),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  int checks = 0;
  int errors = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int greedy(input int a);
    if (a >= 50) return 50;
    if (a >= 20) return 20;
    if (a >= 10) return 10;
    if (a >= 5) return 5;
    return 1;
  endfunction

  function automatic int onehot(input int v);
    case (v)
      50: return 16;
      20: return 8;
      10: return 4;
      5:  return 2;
      1:  return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int decode(input logic [4:0] t);
    case (t)
      5'b10000: return 50;
      5'b01000: return 20;
      5'b00100: return 10;
      5'b00010: return 5;
      5'b00001: return 1;
      default:  return -1;
    endcase
  endfunction

  // payout model: balance, coin owed next, and a countdown to the next offer
  bit m_live = 1'b0;
  bit m_busy, m_valid, m_done, m_err;
  int m_rem, m_coin, m_wait;
  bit was_done, m_hs;

  always @(posedge sys_clk) begin
    m_live = 1'b1;
    if (!sys_rst_n) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_err = 0;
      m_rem = 0; m_coin = 0; m_wait = 0;
    end else begin
      was_done = m_done;
      m_hs = m_valid && coin_ready;
      m_done = 0;
      m_err = 0;
      if (!m_busy) begin
        if (start) begin
          if (LIMIT && change_money > 200) begin
            m_err = 1;
          end else begin
            m_rem = int'(change_money);
            m_busy = 1;
            if (m_rem == 0) m_done = 1;
            else begin
              m_coin = greedy(m_rem);
              m_wait = 2;
            end
          end
        end
      end else if (abort) begin
        if (m_hs) m_rem -= m_coin;
        m_valid = 0;
        m_busy = 0;
        m_wait = 0;
      end else if (was_done) begin
        m_busy = 0;
      end else if (m_hs) begin
        m_rem -= m_coin;
        m_valid = 0;
        if (m_rem == 0) m_done = 1;
        else begin
          m_coin = greedy(m_rem);
          m_wait = GAP + 2;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end
    end
  end

  int coin_q[$];
  int rem_q[$];
  int done_cnt, valid_cnt, last_coin, cv;
  bit pend;

  always @(negedge sys_clk) begin
    if (m_live) begin
      chk("coin_valid", int'(coin_valid), int'(m_valid));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      chk("remaining", int'(remaining), m_rem);
      if (m_valid) chk("coin_type", int'(coin_type), onehot(m_coin));
      if (pend) begin
        rem_q.push_back(int'(remaining));
        pend = 0;
      end
      if (!busy) last_coin = 100;
      if (coin_valid && coin_ready) begin
        cv = decode(coin_type);
        coin_q.push_back(cv);
        chk("coin_order", int'(cv <= last_coin), 1);
        last_coin = cv;
        pend = 1;
      end
      if (done) done_cnt++;
      if (coin_valid) valid_cnt++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_log();
    coin_q.delete();
    rem_q.delete();
    done_cnt = 0;
    valid_cnt = 0;
  endtask

  task automatic pulse_start(input int v);
    start = 1'b1;
    change_money = 8'(v);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_bound", int'(n < bound), 1);
    tick();
  endtask

  task automatic check_list(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(nm, got[i], exp[i]);
    end
  endtask

  initial begin
    int e[$];
    int n;
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    int n, amt;
    sys_rst_n = 1'b0;
    start = 1'b0;
    change_money = 8'd0;
    abort = 1'b0;
    coin_ready = 1'b0;
    done_cnt = 0; valid_cnt = 0; last_coin = 100; pend = 0;
    repeat (3) tick();
    chk("rst_valid", int'(coin_valid), 0);
    chk("rst_type", int'(coin_type), 0);
    chk("rst_rem", int'(remaining), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    sys_rst_n = 1'b1;
    tick();

    // 76 with ready always high
    clear_log();
    coin_ready = 1'b1;
    pulse_start(76);
    chk("lat76_n", int'(coin_valid), 0);
    tick();
    chk("lat76_n1", int'(coin_valid), 0);
    tick();
    chk("lat76_n2", int'(coin_valid), 1);
    wait_idle(200);
    e = '{50, 20, 5, 1};
    check_list("coins76", coin_q, e);
    e = '{26, 6, 1, 0};
    check_list("rem76", rem_q, e);
    chk("done76", done_cnt, 1);

    // zero change
    clear_log();
    pulse_start(0);
    chk("zero_done", int'(done), 1);
    wait_idle(20);
    repeat (3) tick();
    chk("zero_valid", valid_cnt, 0);
    chk("zero_donecnt", done_cnt, 1);

    // 88 with a stalled first offer
    clear_log();
    coin_ready = 1'b0;
    pulse_start(88);
    n = 0;
    while (!coin_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall_bound", int'(n < 20), 1);
    repeat (10) begin
      chk("stall_type", int'(coin_type), 16);
      tick();
    end
    coin_ready = 1'b1;
    wait_idle(300);
    e = '{50, 20, 10, 5, 1, 1, 1};
    check_list("coins88", coin_q, e);
    chk("done88", done_cnt, 1);

    // abort on the 20 handshake
    clear_log();
    pulse_start(76);
    n = 0;
    while (!(coin_valid && coin_type == 5'b01000) && n < 50) begin
      tick();
      n++;
    end
    chk("abort_bound", int'(n < 50), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(coin_valid), 0);
    chk("abort_rem", int'(remaining), 6);
    repeat (4) tick();
    chk("abort_done", done_cnt, 0);
    chk("abort_hold", int'(remaining), 6);

    // reset in the gap after the first coin
    clear_log();
    pulse_start(76);
    n = 0;
    while (coin_q.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    chk("gaprst_bound", int'(n < 50), 1);
    sys_rst_n = 1'b0;
    tick();
    chk("gaprst_valid", int'(coin_valid), 0);
    chk("gaprst_type", int'(coin_type), 0);
    chk("gaprst_rem", int'(remaining), 0);
    chk("gaprst_busy", int'(busy), 0);
    chk("gaprst_done", int'(done), 0);
    chk("gaprst_err", int'(err), 0);
    sys_rst_n = 1'b1;
    repeat (3) tick();
    chk("gaprst_idle", int'(busy), 0);

    // 230: rejected or paid depending on the build
    clear_log();
    pulse_start(230);
    if (LIMIT) begin
      chk("lim_err", int'(err), 1);
      chk("lim_busy", int'(busy), 0);
      tick();
      chk("lim_err_pulse", int'(err), 0);
      chk("lim_rem", int'(remaining), 0);
    end else begin
      chk("lim_err", int'(err), 0);
      wait_idle(400);
      e = '{50, 50, 50, 50, 20, 10};
      check_list("coins230", coin_q, e);
    end

    // random payouts with stalls, aborts and stray starts
    for (int p = 0; p < 60; p++) begin
      amt = int'($urandom_range(0, 255));
      coin_ready = $urandom_range(0, 1) == 1;
      pulse_start(amt);
      n = 0;
      while (busy && n < 500) begin
        coin_ready = ($urandom % 4) != 0;
        abort = ($urandom % 80) == 0;
        start = ($urandom % 10) == 0;
        change_money = 8'($urandom);
        tick();
        n++;
      end
      chk("rand_bound", int'(n < 500), 1);
      start = 1'b0;
      abort = 1'b0;
      coin_ready = $urandom_range(0, 1) == 1;
      repeat (2) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, idle cycles between two coin offers (0 = back-to-back).
REQ-002 SHALL have ports, clock and reset first:
- sys_clk  in  1  single system clock; all logic on its rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latch change_money and begin payout.
- change_money  in  8  change amount, in units of 1.
- abort  in  1  one-cycle pulse; stop payout.
- coin_ready  in  1  mechanism accepts the offered coin this cycle.
- coin_valid  out  1  a coin is offered.
- coin_type  out  5  one-hot denomination; bit0=1, bit1=5, bit2=10, bit3=20, bit4=50.
- remaining  out  8  amount still to be paid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when payout completes.
- err  out  1  one-cycle pulse when start is rejected.
REQ-003 SHALL register every output; none depends combinationally on an input.

Function
REQ-004 SHALL implement the FSM states IDLE, SELECT, OFFER, GAP and DONE.
REQ-005 IDLE: on start, SHALL load remaining=change_money. If the value is 0, go to DONE; otherwise go to SELECT.
REQ-006 SHALL ignore start in every state except IDLE.
REQ-007 SELECT (one cycle): SHALL choose the largest denomination <= remaining, load coin_type and go to OFFER.
REQ-008 OFFER: coin_valid=1. coin_type SHALL stay stable until a handshake, defined as coin_valid&coin_ready at a clock edge.
REQ-009 On handshake SHALL set remaining -= denomination and deassert coin_valid on the next cycle.
REQ-010 After a handshake SHALL go to DONE if remaining is now 0. Otherwise go to GAP, or straight to SELECT if GAP_CYCLES=0.
REQ-011 GAP: SHALL count exactly GAP_CYCLES cycles, then go to SELECT.
REQ-012 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-013 Greedy selection guarantees the subtraction never underflows. remaining SHALL never wrap.
REQ-014 Timing: for start sampled at edge N, coin_valid SHALL first be high in the cycle after edge N+2, and done in the cycle after the edge of the final handshake.
REQ-015 abort in any non-IDLE state: SHALL go to IDLE at the next edge and clear coin_valid. done SHALL NOT pulse. remaining SHALL hold the unpaid amount until the next start.
REQ-016 If abort and a handshake occur in the same cycle, abort SHALL win, but that coin SHALL still be subtracted from remaining.
REQ-017 coin_ready while coin_valid=0 SHALL have no effect.
REQ-018 Coins SHALL always be paid in non-increasing denomination order.

Reset
REQ-019 With sys_rst_n=0 at a clock edge, SHALL enter IDLE with coin_valid=0, coin_type=0, remaining=0, busy=0, done=0, err=0 and the gap counter at 0.
REQ-020 Reset mid-payout SHALL abandon the payout with no done or err pulse. Reset SHALL dominate start and abort.

Configuration
REQ-021 Macro CHANGE_LIMIT_EN, when defined: start with change_money > 200 SHALL be rejected. err pulses for one cycle, the FSM stays in IDLE and remaining is unchanged.
REQ-022 When CHANGE_LIMIT_EN is undefined: every value 0..255 SHALL be accepted and err SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover these scenarios:
- GAP_CYCLES=2, start with 76, coin_ready always 1 -> coins 50,20,5,1; remaining 26,6,1,0; one done pulse.
- start with 0 -> done in the cycle after the start edge; coin_valid never asserted.
- start with 88, coin_ready held 0 for 10 cycles on the first offer -> coin_type=bit4 stable throughout; then coins 50,20,10,5,1,1,1.
- start with 76, abort in the same cycle as the 20 handshake -> IDLE next cycle, remaining=6, no done.
- Reset asserted during the GAP after the first coin -> all outputs 0 next cycle, FSM in IDLE.
- start with 230: CHANGE_LIMIT_EN defined -> err pulse, busy stays 0; undefined -> coins 50,50,50,50,20,10.
